// File: rtl/postage_filter_deadlock_watchdog.sv
// postage_filter_deadlock_watchdog: flags THRESHOLD consecutive blocked cycles as a sticky deadlock
// and keeps stall statistics.
module postage_filter_deadlock_watchdog #(
    parameter int unsigned THRESHOLD = 1024,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned EVT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             block,
    input  logic             enable,
    input  logic             clear,
    output logic             deadlock,
    output logic             deadlock_pulse,
    output logic [EVT_W-1:0] event_count,
    output logic [CNT_W-1:0] max_stall,
    output logic [CNT_W-1:0] run_len
);
    typedef enum logic [1:0] {IDLE, STALL, DEADLOCK} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);
    state_t state, state_nxt;
    logic [CNT_W-1:0] run_nxt, run_inc, max_base, max_nxt;
    logic [EVT_W-1:0] evt_base, evt_nxt;
    logic det, ending, dl_nxt;
    always_comb begin
        run_inc = &run_len ? run_len : run_len + CNT_W'(1);
        state_nxt = state;
        run_nxt = run_len;
        det = 1'b0;
        ending = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            run_nxt = '0;
        end else if (state == IDLE) begin
            if (block) begin
                run_nxt = CNT_W'(1);
                det = (THRESHOLD == 1);
                state_nxt = det ? DEADLOCK : STALL;
            end
        end else if (block) begin
            run_nxt = run_inc;
            det = (state == STALL) && (run_len == LAST);
            state_nxt = det ? DEADLOCK : state;
        end else begin
            state_nxt = IDLE;
            run_nxt = '0;
            ending = 1'b1;
        end
        // clear zeroes the statistics first so a coinciding detection or stall end still lands
        evt_base = clear ? '0 : event_count;
        evt_nxt = (det && !(&evt_base)) ? evt_base + EVT_W'(1) : evt_base;
        dl_nxt = (deadlock && !clear) || det;
        max_base = clear ? '0 : max_stall;
        max_nxt = (ending && run_len > max_base) ? run_len : max_base;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            run_len <= '0;
            deadlock <= 1'b0;
            deadlock_pulse <= 1'b0;
            event_count <= '0;
            max_stall <= '0;
        end else begin
            state <= state_nxt;
            run_len <= run_nxt;
            deadlock <= dl_nxt;
            deadlock_pulse <= det;
            event_count <= evt_nxt;
            max_stall <= max_nxt;
        end
    end
endmodule

// File: tb/tb_postage_filter_deadlock_watchdog.sv
// tb_postage_filter_deadlock_watchdog: directed and random stimulus against a run-length reference model.
module tb_postage_filter_deadlock_watchdog;
    localparam int THRESHOLD = 4;
    localparam int CNT_W = 32;
    localparam int EVT_W = 3;
    localparam int EVT_MAX = (1 << EVT_W) - 1;
    logic clock = 1'b0;
    logic reset, block, enable, clear;
    logic deadlock, deadlock_pulse;
    logic [EVT_W-1:0] event_count;
    logic [CNT_W-1:0] max_stall, run_len;
    int checks = 0;
    int errors = 0;
    int m_run, m_ev, m_max;
    bit m_dl, m_pulse;
    int pulses = 0;

    postage_filter_deadlock_watchdog #(.THRESHOLD(THRESHOLD), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
        .clock(clock), .reset(reset), .block(block), .enable(enable), .clear(clear),
        .deadlock(deadlock), .deadlock_pulse(deadlock_pulse), .event_count(event_count),
        .max_stall(max_stall), .run_len(run_len)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".deadlock"}, 32'(deadlock), 32'(m_dl));
        check({tag, ".pulse"}, 32'(deadlock_pulse), 32'(m_pulse));
        check({tag, ".event_count"}, 32'(event_count), 32'(m_ev));
        check({tag, ".max_stall"}, max_stall, 32'(m_max));
        check({tag, ".run_len"}, run_len, 32'(m_run));
    endtask

    task automatic model_reset();
        m_run = 0; m_ev = 0; m_max = 0; m_dl = 0; m_pulse = 0;
    endtask

    // A run is the count of consecutive enabled block samples; the THRESHOLD-th one is the detection.
    task automatic step(input string tag, input logic b, input logic e, input logic c);
        int old_run;
        bit det, ended;
        block = b; enable = e; clear = c;
        @(posedge clock);
        old_run = m_run;
        m_run = (e && b) ? old_run + 1 : 0;
        det = e && b && (m_run == THRESHOLD);
        ended = e && !b && (old_run > 0);
        m_pulse = det;
        if (c) begin m_dl = 0; m_ev = 0; m_max = 0; end
        if (det) begin m_dl = 1; m_ev = (m_ev < EVT_MAX) ? m_ev + 1 : EVT_MAX; end
        if (ended && old_run > m_max) m_max = old_run;
        #1;
        if (deadlock_pulse) pulses++;
        check_all(tag);
    endtask

    task automatic blocks(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; block = 1'b0; enable = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset = 1'b0;
        // short stall below threshold
        blocks("r033", 3);
        step("r033_end", 1'b0, 1'b1, 1'b0);
        check("r033_no_pulse", 32'(pulses), 32'd0);
        // long stall through detection
        blocks("r034", 10);
        check("r034_one_pulse", 32'(pulses), 32'd1);
        step("r034_end", 1'b0, 1'b1, 1'b0);
        step("r034_quiet", 1'b0, 1'b1, 1'b1);
        // two runs split by one idle cycle
        pulses = 0;
        blocks("r035a", 5);
        step("r035_gap", 1'b0, 1'b1, 1'b0);
        blocks("r035b", 5);
        step("r035_end", 1'b0, 1'b1, 1'b0);
        check("r035_two_pulses", 32'(pulses), 32'd2);
        // clear on the second detection, then in a quiet cycle
        step("r036_clr0", 1'b0, 1'b1, 1'b1);
        blocks("r036a", 4);
        step("r036_gap", 1'b0, 1'b1, 1'b0);
        blocks("r036b", 3);
        step("r036_det_clr", 1'b1, 1'b1, 1'b1);
        step("r036_end", 1'b0, 1'b1, 1'b0);
        step("r036_quiet_clr", 1'b0, 1'b1, 1'b1);
        // enable drop mid-stall, clear on a stall end
        blocks("r037a", 3);
        step("r037_off0", 1'b1, 1'b0, 1'b0);
        step("r037_off1", 1'b1, 1'b0, 1'b0);
        blocks("r037b", 5);
        step("r028_end_clr", 1'b0, 1'b1, 1'b1);
        // async reset between edges while in DEADLOCK
        blocks("r038", 6);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("r038_async");
        #1 reset = 1'b0;
        step("r032_first", 1'b1, 1'b1, 1'b0);
        step("r032_end", 1'b0, 1'b1, 1'b0);
        // event counter saturation
        for (int k = 0; k < EVT_MAX + 2; k++) begin
            blocks("sat", 4);
            step("sat_gap", 1'b0, 1'b1, 1'b0);
        end
        // random traffic
        for (int i = 0; i < 3000; i++)
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, $urandom_range(0, 31) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/postage_filter_deadlock_watchdog.md
POSTAGE_FILTER_DEADLOCK_WATCHDOG -- requirements
Module: postage_filter_deadlock_watchdog

Interface
REQ-001 Parameter THRESHOLD, default 1024, consecutive blocked cycles that constitute a deadlock; legal range is 1 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 32, width of the stall-length counters.
REQ-003 Parameter EVT_W, default 16, width of the deadlock event counter.
REQ-004 clock  input  1  sole clock; all logic is on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 block  input  1  stall indication from the deadlock-index monitor, sampled every cycle.
REQ-007 enable  input  1  1 = watchdog armed; 0 = detection suspended.
REQ-008 clear  input  1  single-cycle synchronous clear of the sticky status and statistics.
REQ-009 deadlock  output  1  sticky flag, set on detection and held until clear or reset.
REQ-010 deadlock_pulse  output  1  one-cycle strobe on each detection.
REQ-011 event_count  output  EVT_W  number of detections since the last clear.
REQ-012 max_stall  output  CNT_W  longest completed stall, in cycles, since the last clear.
REQ-013 run_len  output  CNT_W  length of the current stall run; 0 when not stalled.

Function
REQ-014 The FSM SHALL have three states: IDLE, STALL and DEADLOCK; all outputs are registered.
REQ-015 IDLE, enable=1, block=1: run_len SHALL become 1, and the next state SHALL be DEADLOCK if THRESHOLD=1, otherwise STALL.
REQ-016 STALL, block=1: run_len SHALL increment.
REQ-017 In STALL, when run_len=THRESHOLD-1 and block=1, the next state SHALL be DEADLOCK; in that same cycle deadlock and deadlock_pulse SHALL be set and event_count SHALL increment.
REQ-018 DEADLOCK, block=1: run_len SHALL increment and no further pulse or count SHALL occur.
REQ-019 STALL or DEADLOCK, block=0: next state IDLE, run_len SHALL become 0, and max_stall SHALL be loaded with the old run_len if it is larger.
REQ-020 deadlock_pulse SHALL be high for exactly one cycle per entry into DEADLOCK and low otherwise.
REQ-021 Detection latency: deadlock SHALL be visible in the cycle after the THRESHOLD-th consecutive sampled block=1.
REQ-022 run_len and event_count SHALL saturate at all-ones, never wrap.
REQ-023 The deadlock flag SHALL stay set after block deasserts; only clear or reset SHALL drop it.
REQ-024 enable=0 SHALL force the next state to IDLE and run_len to 0, produce no pulse, and leave max_stall unchanged; deadlock and event_count SHALL hold.
REQ-025 An enable falling mid-stall SHALL NOT update max_stall.
REQ-026 clear=1 SHALL zero deadlock, event_count and max_stall; it SHALL NOT affect the state or run_len.
REQ-027 clear coinciding with detection: deadlock=1, deadlock_pulse=1, event_count=1.
REQ-028 clear coinciding with the end of a stall: max_stall SHALL equal the ending run_len.
REQ-029 A one-cycle block=0 gap SHALL end the run; the next run SHALL restart from 1.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE and deadlock=0, deadlock_pulse=0, event_count=0, max_stall=0 and run_len=0, regardless of clock.
REQ-031 reset asserted mid-stall or in DEADLOCK SHALL discard the run without updating max_stall.
REQ-032 After reset deasserts, the first sampled block=1 SHALL count as run_len=1.

Verification (THRESHOLD=4)
REQ-033 enable=1, block=1 for 3 cycles, then 0 -> no deadlock, deadlock_pulse never high, max_stall=3, event_count=0.
REQ-034 block=1 for 10 cycles -> deadlock and one pulse in the cycle after the 4th sample, run_len reaches 10, then max_stall=10, event_count=1, deadlock stays 1.
REQ-035 Two 5-cycle stalls separated by 1 idle cycle -> event_count=2, two separate pulses, max_stall=5.
REQ-036 clear in the detection cycle of the 2nd deadlock -> event_count=1, deadlock=1; clear in a later quiet cycle -> all statistics 0.
REQ-037 enable dropped at run_len=3, block held -> run_len=0, no detection; re-enable -> detection 4 cycles later.
REQ-038 Async reset pulse between clock edges while in DEADLOCK -> all outputs 0 immediately, and max_stall remains 0.
